// File: rtl/transpose_pingpong_ctrl_pkg.sv
// Shared definitions for the DCT transpose ping-pong bank controller.
package transpose_pingpong_ctrl_pkg;

    localparam int ROWS_DEFAULT  = 8;
    localparam int IDX_W_DEFAULT = 3;

    // Life cycle of one 8x8 bank: rows go in, then columns come out.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // A bank can take a row until its last row has been written.
    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    // A bank can deliver columns from the moment it is completely filled.
    function automatic logic bank_readable(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/transpose_pingpong_ctrl_bank_state_fsm.sv
// Occupancy state of a single transpose bank (one instance per bank).
module bank_state_fsm
    import transpose_pingpong_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_first,
    input  logic wr_last,
    input  logic rd_first,
    input  logic rd_last,
    output logic writable,
    output logic readable,
    output logic empty
);

    bank_state_e state;
    bank_state_e state_nxt;

    // State register; reset discards whatever partial block the bank held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BANK_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Advance on the first/last row written and the first/last column read.
    always_comb begin
        state_nxt = state;
        case (state)
            BANK_EMPTY: begin
                if (wr_first) begin
                    state_nxt = wr_last ? BANK_FULL : BANK_FILLING;
                end
            end
            BANK_FILLING: begin
                if (wr_last) begin
                    state_nxt = BANK_FULL;
                end
            end
            BANK_FULL: begin
                if (rd_first) begin
                    state_nxt = rd_last ? BANK_EMPTY : BANK_DRAINING;
                end
            end
            BANK_DRAINING: begin
                if (rd_last) begin
                    state_nxt = BANK_EMPTY;
                end
            end
            default: state_nxt = BANK_EMPTY;
        endcase
    end

    assign writable = bank_writable(state);
    assign readable = bank_readable(state);
    assign empty    = (state == BANK_EMPTY);

endmodule

// File: rtl/transpose_pingpong_ctrl.sv
// Ping-pong sequencer for the two 8x8 transpose banks: rows in, columns out.
module transpose_pingpong_ctrl
    import transpose_pingpong_ctrl_pkg::*;
#(
    parameter int ROWS   = ROWS_DEFAULT,
    parameter int IDX_W  = IDX_W_DEFAULT,
    parameter int BCNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [1:0]        o_wr_en,
    output logic [IDX_W-1:0]  o_wr_row,
    input  logic              i_out_ready,
    output logic [1:0]        o_rd_en,
    output logic [IDX_W-1:0]  o_rd_col,
    output logic              o_rd_sel,
    output logic              o_out_valid,
    output logic              o_out_last,
    output logic [BCNT_W-1:0] o_blk_cnt,
    output logic              o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    logic              wr_sel;
    logic              rd_sel;
    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  rd_cnt;
    logic [BCNT_W-1:0] blk_cnt;

    logic [1:0] writable;
    logic [1:0] readable;
    logic [1:0] empty;
    logic [1:0] wr_first;
    logic [1:0] wr_last;
    logic [1:0] rd_first;
    logic [1:0] rd_last;

    logic wr_fire;
    logic rd_fire;
    logic wr_at_end;
    logic rd_at_end;

    logic out_valid_p1;
    logic rd_sel_p1;
    logic out_last_p1;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign o_in_ready = i_rst_n & writable[wr_sel];
    assign wr_fire    = i_in_valid & o_in_ready;
    assign rd_fire    = readable[rd_sel] & i_out_ready;
    assign wr_at_end  = (wr_cnt == LAST_IDX);
    assign rd_at_end  = (rd_cnt == LAST_IDX);

    assign o_wr_en  = {wr_fire & wr_sel, wr_fire & ~wr_sel};
    assign o_rd_en  = {rd_fire & rd_sel, rd_fire & ~rd_sel};
    assign o_wr_row = wr_cnt;
    assign o_rd_col = rd_cnt;

    // Per-bank events; the strobes already carry the bank selection.
    assign wr_first = o_wr_en & {2{wr_cnt == '0}};
    assign wr_last  = o_wr_en & {2{wr_at_end}};
    assign rd_first = o_rd_en & {2{rd_cnt == '0}};
    assign rd_last  = o_rd_en & {2{rd_at_end}};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bank_state_fsm u_fsm (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .wr_first (wr_first[b]),
            .wr_last  (wr_last[b]),
            .rd_first (rd_first[b]),
            .rd_last  (rd_last[b]),
            .writable (writable[b]),
            .readable (readable[b]),
            .empty    (empty[b])
        );
    end

    // Row counter and write-bank pointer; pauses on input gaps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
        end else if (wr_fire) begin
            if (wr_at_end) begin
                wr_cnt <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Column counter, read-bank pointer and drained-block count; pauses without credit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_cnt  <= '0;
            rd_sel  <= 1'b0;
            blk_cnt <= '0;
        end else if (rd_fire) begin
            if (rd_at_end) begin
                rd_cnt  <= '0;
                rd_sel  <= ~rd_sel;
                blk_cnt <= blk_cnt + 1'b1;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Stage p0 -> p1: align valid/select/last with the bank read data one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_p1 <= 1'b0;
            rd_sel_p1    <= 1'b0;
            out_last_p1  <= 1'b0;
        end else begin
            out_valid_p1 <= rd_fire;
            rd_sel_p1    <= rd_sel;
            out_last_p1  <= rd_fire & rd_at_end;
        end
    end

    assign o_out_valid = out_valid_p1;
    assign o_rd_sel    = rd_sel_p1;
    assign o_out_last  = out_last_p1;
    assign o_blk_cnt   = blk_cnt;
    assign o_busy      = ~empty[0] | ~empty[1] | out_valid_p1;

endmodule

// File: tb/tb_transpose_pingpong_ctrl.sv
// Self-checking bench for the transpose ping-pong controller.
module tb_transpose_pingpong_ctrl;

    localparam int ROWS   = 8;
    localparam int IDX_W  = 3;
    localparam int BCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              out_ready;
    logic              o_in_ready;
    logic [1:0]        o_wr_en;
    logic [IDX_W-1:0]  o_wr_row;
    logic [1:0]        o_rd_en;
    logic [IDX_W-1:0]  o_rd_col;
    logic              o_rd_sel;
    logic              o_out_valid;
    logic              o_out_last;
    logic [BCNT_W-1:0] o_blk_cnt;
    logic              o_busy;

    transpose_pingpong_ctrl #(.ROWS(ROWS), .IDX_W(IDX_W), .BCNT_W(BCNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (o_in_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_row    (o_wr_row),
        .i_out_ready (out_ready),
        .o_rd_en     (o_rd_en),
        .o_rd_col    (o_rd_col),
        .o_rd_sel    (o_rd_sel),
        .o_out_valid (o_out_valid),
        .o_out_last  (o_out_last),
        .o_blk_cnt   (o_blk_cnt),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Reference model: rows stored and columns read per bank.
    int m_rows [2];
    int m_cols [2];
    int m_wsel;
    int m_rsel;
    int m_blk;
    logic exp_wf;
    logic exp_rf;

    typedef struct packed {
        logic sel;
        logic last;
    } sb_t;
    sb_t sb[$];

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int nlast    = 0;

    typedef struct {
        int   cycles;
        logic iv;
        logic ordy;
        int   exp_blk;
        logic exp_busy;
    } phase_t;
    phase_t phases[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rows[0] = 0; m_rows[1] = 0;
        m_cols[0] = 0; m_cols[1] = 0;
        m_wsel = 0; m_rsel = 0; m_blk = 0;
        exp_wf = 1'b0; exp_rf = 1'b0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  32'(o_in_ready),  32'd0);
        check({tag, "_wr_en"},     32'(o_wr_en),     32'd0);
        check({tag, "_wr_row"},    32'(o_wr_row),    32'd0);
        check({tag, "_rd_en"},     32'(o_rd_en),     32'd0);
        check({tag, "_rd_col"},    32'(o_rd_col),    32'd0);
        check({tag, "_rd_sel"},    32'(o_rd_sel),    32'd0);
        check({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
        check({tag, "_out_last"},  32'(o_out_last),  32'd0);
        check({tag, "_blk_cnt"},   32'(o_blk_cnt),   32'd0);
        check({tag, "_busy"},      32'(o_busy),      32'd0);
    endtask

    // Drive inputs at the falling edge and check the combinational strobes.
    task automatic setup(input logic iv, input logic ordy);
        logic exp_ir;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        #1;
        exp_ir = (m_rows[m_wsel] < ROWS);
        exp_wf = iv && exp_ir;
        exp_rf = (m_rows[m_rsel] == ROWS) && ordy;
        check("in_ready", 32'(o_in_ready), 32'(exp_ir));
        check("wr_en", 32'(o_wr_en), 32'(exp_wf ? (m_wsel == 1 ? 2'b10 : 2'b01) : 2'b00));
        if (exp_ir) check("wr_row", 32'(o_wr_row), 32'(m_rows[m_wsel]));
        check("rd_en", 32'(o_rd_en), 32'(exp_rf ? (m_rsel == 1 ? 2'b10 : 2'b01) : 2'b00));
        if (m_rows[m_rsel] == ROWS) check("rd_col", 32'(o_rd_col), 32'(m_cols[m_rsel]));
        check("wr_rd_overlap", 32'(o_wr_en & o_rd_en), 32'd0);
        if (exp_rf) sb.push_back('{sel: (m_rsel == 1), last: (m_cols[m_rsel] == ROWS - 1)});
    endtask

    // Clock edge: update the model, then check the registered outputs.
    task automatic advance();
        logic exp_busy;
        sb_t  e;
        @(posedge clk);
        if (exp_wf) begin
            m_rows[m_wsel]++;
            if (m_rows[m_wsel] == ROWS) m_wsel ^= 1;
        end
        if (exp_rf) begin
            m_cols[m_rsel]++;
            if (m_cols[m_rsel] == ROWS) begin
                m_rows[m_rsel] = 0;
                m_cols[m_rsel] = 0;
                m_rsel ^= 1;
                m_blk++;
            end
        end
        #1;
        check("out_valid", 32'(o_out_valid), 32'(exp_rf));
        if (o_out_valid) begin
            nvalid++;
            if (o_out_last) nlast++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rd_sel", 32'(o_rd_sel), 32'(e.sel));
                check("out_last", 32'(o_out_last), 32'(e.last));
            end
        end
        check("blk_cnt", 32'(o_blk_cnt), 32'(m_blk[BCNT_W-1:0]));
        exp_busy = (m_rows[0] != 0) || (m_rows[1] != 0) || exp_rf;
        check("busy", 32'(o_busy), 32'(exp_busy));
    endtask

    task automatic step(input logic iv, input logic ordy);
        setup(iv, ordy);
        advance();
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        #1;
        check("ready_after_release", 32'(o_in_ready), 32'd1);
    endtask

    initial begin
        int v0;
        int l0;

        phases[0] = '{8,  1'b1, 1'b1, 0, 1'b1};
        phases[1] = '{12, 1'b0, 1'b1, 1, 1'b0};
        phases[2] = '{24, 1'b1, 1'b1, 3, 1'b1};
        phases[3] = '{12, 1'b0, 1'b1, 4, 1'b0};
        phases[4] = '{17, 1'b1, 1'b0, 4, 1'b1};
        phases[5] = '{8,  1'b0, 1'b1, 5, 1'b1};
        phases[6] = '{12, 1'b0, 1'b1, 6, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("ready_after_release", 32'(o_in_ready), 32'd1);

        // Single block, back-to-back traffic, and both-banks-full backpressure.
        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < phases[p].cycles; c++) step(phases[p].iv, phases[p].ordy);
            check($sformatf("phase%0d_blk", p), 32'(o_blk_cnt), 32'(phases[p].exp_blk));
            check($sformatf("phase%0d_busy", p), 32'(o_busy), 32'(phases[p].exp_busy));
        end

        // Drain with credit toggling every cycle.
        v0 = nvalid;
        l0 = nlast;
        for (int i = 0; i < ROWS; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2 * ROWS; i++) step(1'b0, (i % 2) == 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("toggle_valids", 32'(nvalid - v0), 32'd8);
        check("toggle_lasts", 32'(nlast - l0), 32'd1);
        check("toggle_blk", 32'(o_blk_cnt), 32'd7);

        // Reset after a partial block discards it.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        do_reset();
        v0 = nvalid;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("partial_no_valid", 32'(nvalid - v0), 32'd0);
        check("partial_blk", 32'(o_blk_cnt), 32'd0);
        v0 = nvalid;
        for (int i = 0; i < ROWS; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("fresh_block_valids", 32'(nvalid - v0), 32'd8);
        check("fresh_block_blk", 32'(o_blk_cnt), 32'd1);

        // Bank1 finishes filling in the same cycle bank0 finishes draining.
        do_reset();
        for (int i = 0; i < ROWS; i++) step(1'b1, 1'b0);
        for (int i = 0; i < ROWS; i++) step(1'b1, 1'b1);
        setup(1'b1, 1'b1);
        check("coinc_wr_en", 32'(o_wr_en), 32'd1);
        check("coinc_wr_row", 32'(o_wr_row), 32'd0);
        check("coinc_rd_en", 32'(o_rd_en), 32'd2);
        check("coinc_rd_col", 32'(o_rd_col), 32'd0);
        advance();
        for (int i = 0; i < ROWS - 1; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("coinc_blk", 32'(o_blk_cnt), 32'd3);
        check("coinc_busy", 32'(o_busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
